// File: rtl/noc_initiator.sv
// Host-side NOC initiator: serialises local read/write requests into byte-wide
// request packets and parses the device's response packets back into rdata/done.
module noc_initiator #(
    parameter int TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_write,
    input  logic [4:0] i_req_len,
    input  logic [7:0] i_req_dest,
    input  logic [7:0] i_req_addr,
    input  logic       i_wdata_valid,
    output logic       o_wdata_ready,
    input  logic [7:0] i_wdata,
    output logic       o_rdata_valid,
    output logic [7:0] o_rdata,
    output logic       o_rdata_last,
    output logic       o_done,
    output logic       o_err,
    output logic       o_noc_to_dev_ctl,
    output logic [7:0] o_noc_to_dev_data,
    input  logic       i_noc_from_dev_ctl,
    input  logic [7:0] i_noc_from_dev_data
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WLOAD    = 4'd1;
    localparam logic [3:0] S_TX_CMD   = 4'd2;
    localparam logic [3:0] S_TX_DEST  = 4'd3;
    localparam logic [3:0] S_TX_ADDR  = 4'd4;
    localparam logic [3:0] S_TX_DATA  = 4'd5;
    localparam logic [3:0] S_WAIT_RSP = 4'd6;
    localparam logic [3:0] S_RX_ID    = 4'd7;
    localparam logic [3:0] S_RX_DATA  = 4'd8;

    localparam logic [2:0] OP_RD_REQ = 3'b001;
    localparam logic [2:0] OP_WR_REQ = 3'b010;
    localparam logic [2:0] OP_RD_RSP = 3'b011;
    localparam logic [2:0] OP_WR_RSP = 3'b100;

    localparam int              TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_CNT = TW'(TIMEOUT);

    logic [3:0]    r_state;
    logic          r_write;
    logic [4:0]    r_len;
    logic [7:0]    r_dest;
    logic [7:0]    r_addr;
    logic [4:0]    r_cnt;
    logic [4:0]    r_rsp_len;
    logic          r_err_sticky;
    logic [TW-1:0] r_timer;
    logic          r_tx_ctl;
    logic [7:0]    r_tx_data;
    logic          r_done;
    logic          r_err;
    logic          r_rdata_valid;
    logic [7:0]    r_rdata;
    logic          r_rdata_last;
    logic [7:0]    r_buf [0:30];

    logic          w_accept;
    logic          w_rx_cmd;
    logic          w_op_match;
    logic          w_id_bad;
    logic [TW-1:0] w_timer_next;
    logic          w_timeout;

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_wdata_ready = (r_state == S_WLOAD);

    assign w_accept     = i_req_valid & o_req_ready;
    assign w_rx_cmd     = i_noc_from_dev_ctl & (i_noc_from_dev_data != 8'h00);
    assign w_op_match   = (i_noc_from_dev_data[7:5] == (r_write ? OP_WR_RSP : OP_RD_RSP));
    assign w_id_bad     = (i_noc_from_dev_data != r_dest);
    assign w_timer_next = r_timer + TW'(1);
    assign w_timeout    = (w_timer_next == TIMEOUT_CNT);

    assign o_noc_to_dev_ctl  = r_tx_ctl;
    assign o_noc_to_dev_data = r_tx_data;
    assign o_done            = r_done;
    assign o_err             = r_err;
    assign o_rdata_valid     = r_rdata_valid;
    assign o_rdata           = r_rdata;
    assign o_rdata_last      = r_rdata_last;

    // Whole write payload is buffered so the outgoing packet is contiguous.
    always_ff @(posedge i_clk) begin
        if (r_state == S_WLOAD && i_wdata_valid) begin
            r_buf[r_cnt] <= i_wdata;
        end
    end

    // The to_dev register is loaded with the byte belonging to the state being
    // entered, so each byte is visible for exactly the cycle spent in its state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_len         <= 5'd0;
            r_dest        <= 8'h00;
            r_addr        <= 8'h00;
            r_cnt         <= 5'd0;
            r_rsp_len     <= 5'd0;
            r_err_sticky  <= 1'b0;
            r_timer       <= '0;
            r_tx_ctl      <= 1'b1;
            r_tx_data     <= 8'h00;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= 8'h00;
            r_rdata_last  <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
            r_tx_ctl      <= 1'b1;
            r_tx_data     <= 8'h00;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= i_req_write;
                        r_len   <= i_req_len;
                        r_dest  <= i_req_dest;
                        r_addr  <= i_req_addr;
                        r_cnt   <= 5'd0;
                        if (i_req_len == 5'd0) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (i_req_write) begin
                            r_state <= S_WLOAD;
                        end else begin
                            r_state   <= S_TX_CMD;
                            r_tx_data <= {OP_RD_REQ, i_req_len};
                        end
                    end
                end

                S_WLOAD: begin
                    if (i_wdata_valid) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == r_len - 5'd1) begin
                            r_state   <= S_TX_CMD;
                            r_cnt     <= 5'd0;
                            r_tx_data <= {OP_WR_REQ, r_len};
                        end
                    end
                end

                S_TX_CMD: begin
                    r_state   <= S_TX_DEST;
                    r_tx_ctl  <= 1'b0;
                    r_tx_data <= r_dest;
                end

                S_TX_DEST: begin
                    r_state   <= S_TX_ADDR;
                    r_tx_ctl  <= 1'b0;
                    r_tx_data <= r_addr;
                end

                S_TX_ADDR: begin
                    if (r_write) begin
                        r_state   <= S_TX_DATA;
                        r_tx_ctl  <= 1'b0;
                        r_tx_data <= r_buf[0];
                        r_cnt     <= 5'd1;
                    end else begin
                        r_state <= S_WAIT_RSP;
                        r_timer <= '0;
                    end
                end

                // r_cnt holds the index of the next payload byte to put on the wire.
                S_TX_DATA: begin
                    if (r_cnt == r_len) begin
                        r_state <= S_WAIT_RSP;
                        r_timer <= '0;
                    end else begin
                        r_tx_ctl  <= 1'b0;
                        r_tx_data <= r_buf[r_cnt];
                        r_cnt     <= r_cnt + 5'd1;
                    end
                end

                S_WAIT_RSP: begin
                    if (w_rx_cmd) begin
                        if (w_op_match) begin
                            r_state   <= S_RX_ID;
                            r_rsp_len <= i_noc_from_dev_data[4:0];
                        end else begin
                            r_state      <= S_IDLE;
                            r_done       <= 1'b1;
                            r_err        <= 1'b1;
                            r_err_sticky <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state      <= S_IDLE;
                        r_done       <= 1'b1;
                        r_err        <= 1'b1;
                        r_err_sticky <= 1'b0;
                    end else begin
                        r_timer <= w_timer_next;
                    end
                end

                // A length mismatch is folded into the sticky flag so RX_DATA
                // only has to look at one bit to decide whether to suppress rdata.
                S_RX_ID: begin
                    if (r_write) begin
                        r_state      <= S_IDLE;
                        r_done       <= 1'b1;
                        r_err        <= r_err_sticky | w_id_bad;
                        r_err_sticky <= 1'b0;
                    end else if (r_rsp_len == 5'd0) begin
                        r_state      <= S_IDLE;
                        r_done       <= 1'b1;
                        r_err        <= 1'b1;
                        r_err_sticky <= 1'b0;
                    end else begin
                        r_state      <= S_RX_DATA;
                        r_cnt        <= 5'd0;
                        r_err_sticky <= r_err_sticky | w_id_bad | (r_rsp_len != r_len);
                    end
                end

                S_RX_DATA: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!r_err_sticky) begin
                        r_rdata_valid <= 1'b1;
                        r_rdata       <= i_noc_from_dev_data;
                    end
                    if (r_cnt == r_rsp_len - 5'd1) begin
                        r_rdata_last <= ~r_err_sticky;
                        r_state      <= S_IDLE;
                        r_done       <= 1'b1;
                        r_err        <= r_err_sticky;
                        r_err_sticky <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
